obi_ext_master_bridge: RTL and testbench



---
 rtl/mochila_bridge_pkg.sv | 16 +
 rtl/obi_pkg.sv | 19 +
 rtl/obi_req_fifo.sv | 54 +++++
 rtl/obi_ext_master_bridge.sv | 119 +++++++++++
 tb/tb_obi_ext_master_bridge.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mochila_bridge_pkg.sv
// Defaults and the stored request format for the external-master OBI bridge.
package mochila_bridge_pkg;

  localparam int unsigned DEFAULT_REQ_DEPTH       = 4;
  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 1024;

  // Request fields that travel through the FIFO; req itself is implied by occupancy.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_entry_t;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response channel types shared by every OBI port in the subsystem.
// Fixed 32-bit address/data with byte enables; no optional OBI signals.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_req_fifo.sv
// Power-of-two request FIFO; head is the oldest entry and stays put until popped.
module obi_req_fifo
  import mochila_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_REQ_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  obi_req_entry_t push_data,
  input  logic           pop,
  output logic           full,
  output logic           empty,
  output obi_req_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  obi_req_entry_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count decides which slots are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/obi_ext_master_bridge.sv
// Buffering bridge in front of the external-master OBI port: queued requests,
// bounded outstanding count, registered responses and a sticky timeout flag.
module obi_ext_master_bridge
  import obi_pkg::*;
  import mochila_bridge_pkg::*;
#(
  parameter int unsigned REQ_DEPTH       = DEFAULT_REQ_DEPTH,
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  obi_req_t                             s_req_i,
  output obi_resp_t                            s_resp_o,
  output obi_req_t                             m_req_o,
  input  obi_resp_t                            m_resp_i,
  input  logic                                 clear_i,
  output logic                                 timeout_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT_CYCLES);

  logic           fifo_full;
  logic           fifo_empty;
  obi_req_entry_t head;
  logic           gnt;
  logic           accept;
  logic           pop;
  logic           dec;

  logic [OW-1:0]  outstanding_q, outstanding_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           timeout_q, timeout_d;
  logic           rvalid_q;
  logic [31:0]    rdata_q;

  assign gnt    = !rst_i && !fifo_full && (outstanding_q < MAX_OUT);
  assign accept = s_req_i.req && gnt;
  assign pop    = !fifo_empty && m_resp_i.gnt;
  // A response with nothing outstanding is forwarded but never counted.
  assign dec    = rvalid_q && (outstanding_q != '0);

  obi_req_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (accept),
    .push_data ('{addr: s_req_i.addr, we: s_req_i.we, be: s_req_i.be, wdata: s_req_i.wdata}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    m_req_o = '0;
    if (!fifo_empty) begin
      m_req_o.req   = 1'b1;
      m_req_o.addr  = head.addr;
      m_req_o.we    = head.we;
      m_req_o.be    = head.be;
      m_req_o.wdata = head.wdata;
    end
  end

  assign s_resp_o.gnt    = gnt;
  assign s_resp_o.rvalid = rvalid_q;
  assign s_resp_o.rdata  = rdata_q;
  assign timeout_o       = timeout_q;
  assign outstanding_o   = outstanding_q;

  always_comb begin
    outstanding_d = outstanding_q;
    tcnt_d        = tcnt_q;
    timeout_d     = timeout_q;

    case ({accept, dec})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (TIMEOUT_CYCLES == 0) begin
      tcnt_d    = '0;
      timeout_d = 1'b0;
    end else begin
      if (outstanding_q == '0 || m_resp_i.rvalid) tcnt_d = '0;
      else if (tcnt_q != T_MAX)                   tcnt_d = tcnt_q + TW'(1);
      // Reaching terminal count beats a coincident clear.
      if (tcnt_d == T_MAX && tcnt_q != T_MAX) timeout_d = 1'b1;
      else if (clear_i)                       timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      tcnt_q        <= '0;
      timeout_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      tcnt_q        <= tcnt_d;
      timeout_q     <= timeout_d;
      rvalid_q      <= m_resp_i.rvalid;
      if (m_resp_i.rvalid) rdata_q <= m_resp_i.rdata;
    end
  end

  rsp_without_outstanding: assert property (
    @(posedge clk_i) disable iff (rst_i) rvalid_q |-> (outstanding_q != '0)
  );

endmodule

// File: tb/tb_obi_ext_master_bridge.sv
// Directed bench for obi_ext_master_bridge: single write, backpressure, pipelined
// reads, timeout and asynchronous reset mid-operation.
module tb_obi_ext_master_bridge;
  import obi_pkg::*;

  logic      clk_i = 1'b0;
  logic      rst_i;
  obi_req_t  s_req_i;
  obi_resp_t s_resp_o;
  obi_req_t  m_req_o;
  obi_resp_t m_resp_i;
  logic      clear_i;
  logic      timeout_o;
  logic [2:0] outstanding_o;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk_i = ~clk_i;

  obi_ext_master_bridge #(
    .REQ_DEPTH       (4),
    .MAX_OUTSTANDING (4),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .s_req_i       (s_req_i),
    .s_resp_o      (s_resp_o),
    .m_req_o       (m_req_o),
    .m_resp_i      (m_resp_i),
    .clear_i       (clear_i),
    .timeout_o     (timeout_o),
    .outstanding_o (outstanding_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int exp_out [7] = '{1, 2, 3, 3, 2, 1, 0};
    int exp_rd  [7] = '{0, 0, 'h11, 'h22, 'h33, 'h44, 'h44};

    rst_i    = 1'b1;
    s_req_i  = '0;
    m_resp_i = '0;
    clear_i  = 1'b0;

    // Reset state
    #2;
    check("rst_m_req",   m_req_o,         '0);
    check("rst_gnt",     s_resp_o.gnt,    0);
    check("rst_rvalid",  s_resp_o.rvalid, 0);
    check("rst_rdata",   s_resp_o.rdata,  0);
    check("rst_out",     outstanding_o,   0);
    check("rst_timeout", timeout_o,       0);
    tick();
    rst_i = 1'b0;
    settle();
    check("post_rst_gnt", s_resp_o.gnt, 1);

    // Single write with downstream ready
    m_resp_i.gnt  = 1'b1;
    s_req_i.req   = 1'b1;
    s_req_i.addr  = 32'h2000_0010;
    s_req_i.we    = 1'b1;
    s_req_i.be    = 4'hF;
    s_req_i.wdata = 32'hDEAD_BEEF;
    settle();
    check("wr_no_bypass", m_req_o.req, 0);
    tick();
    s_req_i = '0;
    check("wr_m_req",   m_req_o.req,   1);
    check("wr_m_addr",  m_req_o.addr,  64'h2000_0010);
    check("wr_m_we",    m_req_o.we,    1);
    check("wr_m_be",    m_req_o.be,    4'hF);
    check("wr_m_wdata", m_req_o.wdata, 64'hDEAD_BEEF);
    check("wr_out1",    outstanding_o, 1);
    tick();
    check("wr_popped", m_req_o.req, 0);
    m_resp_i.rvalid = 1'b1;
    m_resp_i.rdata  = 32'h0;
    settle();
    check("wr_rvalid_lat", s_resp_o.rvalid, 0);
    tick();
    m_resp_i.rvalid = 1'b0;
    check("wr_rvalid",   s_resp_o.rvalid, 1);
    check("wr_out_hold", outstanding_o,   1);
    tick();
    check("wr_out0",      outstanding_o,   0);
    check("wr_rvalid_lo", s_resp_o.rvalid, 0);

    // Backpressure: downstream stalls, six reads attempted
    m_resp_i.gnt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_req_i.req  = 1'b1;
      s_req_i.addr = 32'h100 + 32'(4 * i);
      s_req_i.we   = 1'b0;
      s_req_i.be   = 4'hF;
      settle();
      check($sformatf("bp_gnt%0d", i), s_resp_o.gnt, (i < 4) ? 1 : 0);
      tick();
    end
    s_req_i = '0;
    check("bp_out4",  outstanding_o, 4);
    check("bp_req",   m_req_o.req,   1);
    check("bp_addr0", m_req_o.addr,  64'h100);
    tick();
    tick();
    check("bp_stable_addr", m_req_o.addr, 64'h100);
    check("bp_stable_we",   m_req_o.we,   0);
    m_resp_i.gnt = 1'b1;
    for (int j = 0; j < 4; j++) begin
      settle();
      check($sformatf("bp_issue_req%0d", j),  m_req_o.req,  1);
      check($sformatf("bp_issue_addr%0d", j), m_req_o.addr, 64'h100 + 64'(4 * j));
      tick();
    end
    check("bp_drained", m_req_o.req, 0);
    for (int j = 0; j < 4; j++) begin
      m_resp_i.rvalid = 1'b1;
      m_resp_i.rdata  = 32'(j);
      tick();
    end
    m_resp_i.rvalid = 1'b0;
    tick();
    check("bp_out0",    outstanding_o, 0);
    check("bp_timeout", timeout_o,     0);

    // Pipelined reads overlapping with responses
    for (int c = 0; c < 7; c++) begin
      s_req_i = '0;
      if (c < 4) begin
        s_req_i.req  = 1'b1;
        s_req_i.addr = 32'h200 + 32'(4 * c);
        s_req_i.be   = 4'hF;
      end
      m_resp_i.rvalid = (c >= 2 && c <= 5);
      m_resp_i.rdata  = (c >= 2 && c <= 5) ? 32'(17 * (c - 1)) : 32'h0;
      settle();
      if (c >= 1 && c <= 4)
        check($sformatf("pipe_m_addr%0d", c), m_req_o.addr, 64'h200 + 64'(4 * (c - 1)));
      tick();
      check($sformatf("pipe_out%0d", c),    outstanding_o,   64'(exp_out[c]));
      check($sformatf("pipe_rvalid%0d", c), s_resp_o.rvalid, (c >= 2 && c <= 5) ? 1 : 0);
      if (c >= 2)
        check($sformatf("pipe_rdata%0d", c), s_resp_o.rdata, 64'(exp_rd[c]));
    end
    s_req_i         = '0;
    m_resp_i.rvalid = 1'b0;

    // Timeout: one read granted downstream, never answered
    s_req_i.req  = 1'b1;
    s_req_i.addr = 32'h400;
    s_req_i.be   = 4'hF;
    tick();
    s_req_i = '0;
    for (int k = 1; k <= 15; k++) tick();
    check("to_before", timeout_o, 0);
    tick();
    check("to_set", timeout_o, 1);
    tick();
    tick();
    tick();
    check("to_sticky", timeout_o, 1);
    m_resp_i.rvalid = 1'b1;
    m_resp_i.rdata  = 32'hCAFE_0001;
    tick();
    m_resp_i.rvalid = 1'b0;
    tick();
    check("to_after_rvalid", timeout_o,      1);
    check("to_out0",         outstanding_o,  0);
    check("to_rdata",        s_resp_o.rdata, 64'hCAFE_0001);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("to_cleared", timeout_o, 0);

    // Asynchronous reset with requests queued and outstanding
    m_resp_i.gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_req_i.req  = 1'b1;
      s_req_i.addr = 32'h500 + 32'(4 * i);
      tick();
    end
    s_req_i = '0;
    check("ar_pre_out", outstanding_o, 3);
    #2;
    rst_i = 1'b1;
    #1;
    check("ar_m_req",   m_req_o.req,   0);
    check("ar_gnt",     s_resp_o.gnt,  0);
    check("ar_out",     outstanding_o, 0);
    check("ar_timeout", timeout_o,     0);
    tick();
    rst_i        = 1'b0;
    m_resp_i.gnt = 1'b1;
    settle();
    check("ar_gnt_back", s_resp_o.gnt, 1);
    check("ar_empty",    m_req_o.req,  0);
    s_req_i.req   = 1'b1;
    s_req_i.addr  = 32'h3000_0000;
    s_req_i.we    = 1'b1;
    s_req_i.be    = 4'h3;
    s_req_i.wdata = 32'h1234_5678;
    tick();
    s_req_i = '0;
    check("ar_wr_addr",  m_req_o.addr,  64'h3000_0000);
    check("ar_wr_wdata", m_req_o.wdata, 64'h1234_5678);
    check("ar_wr_be",    m_req_o.be,    4'h3);
    check("ar_wr_out1",  outstanding_o, 1);
    tick();
    m_resp_i.rvalid = 1'b1;
    m_resp_i.rdata  = 32'h0;
    tick();
    m_resp_i.rvalid = 1'b0;
    check("ar_wr_rvalid", s_resp_o.rvalid, 1);
    tick();
    check("ar_wr_out0", outstanding_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
